// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants, FSM state type and address composition for the operand matrix
package matrix_pkg;

    localparam int MAX_DIM    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 2 * $clog2(MAX_DIM);
    localparam int DIM_WIDTH  = $clog2(MAX_DIM) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } state_t;

    function automatic logic [ADDR_WIDTH-1:0] compose_addr(
        input logic [DIM_WIDTH-1:0] r,
        input logic [DIM_WIDTH-1:0] c
    );
        return ADDR_WIDTH'(32'(r) * MAX_DIM + 32'(c));
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// rtl/skid_fifo2.sv - two-entry FIFO absorbing registered read returns ahead of the stream consumer
module skid_fifo2 #(
    parameter int WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_o  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_o <= count_o + 2'(push_i) - 2'(pop_i);
        end
    end

    assign data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/operand_fetch_sequencer.sv
// rtl/operand_fetch_sequencer.sv - walks one operand matrix and streams its elements to the multiply datapath
module operand_fetch_sequencer #(
    parameter int DATA_WIDTH = matrix_pkg::DATA_WIDTH,
    parameter int MAX_DIM    = matrix_pkg::MAX_DIM,
    parameter int ADDR_WIDTH = matrix_pkg::ADDR_WIDTH,
    parameter int DIM_WIDTH  = matrix_pkg::DIM_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [DIM_WIDTH-1:0]  rows_i,
    input  logic [DIM_WIDTH-1:0]  cols_i,
    input  logic                  transpose_i,
    output logic [ADDR_WIDTH-1:0] addr_Mat_o,
    input  logic [DATA_WIDTH-1:0] read_data_Mat_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    import matrix_pkg::state_t;
    import matrix_pkg::ST_IDLE;
    import matrix_pkg::ST_FETCH;
    import matrix_pkg::ST_DRAIN;
    import matrix_pkg::compose_addr;

    localparam int CNT_W = ADDR_WIDTH + 1;

    state_t               state_q;
    logic [DIM_WIDTH-1:0] rows_q, cols_q, r_q, c_q, r_n, c_n;
    logic                 tr_q;
    logic [CNT_W-1:0]     total_q, issued_q;
    logic                 infl_q, infl_last_q;
    logic [DATA_WIDTH:0]  head;
    logic [1:0]           fifo_count, occ;
    logic                 pop, iss, is_final, illegal;

    assign illegal  = (rows_i == '0) || (cols_i == '0) ||
                      (rows_i > DIM_WIDTH'(MAX_DIM)) || (cols_i > DIM_WIDTH'(MAX_DIM));
    assign pop      = valid_o && ready_i;
    // Count this cycle's pop as freed space so a steady stream issues every cycle.
    assign occ      = 2'(infl_q) + fifo_count - 2'(pop);
    assign iss      = (state_q == ST_FETCH) && (occ < 2'd2);
    assign is_final = (issued_q == total_q - CNT_W'(1));

    always_comb begin
        r_n = r_q;
        c_n = c_q;
        if (!tr_q) begin
            if (c_q == cols_q - DIM_WIDTH'(1)) begin
                c_n = '0;
                r_n = r_q + DIM_WIDTH'(1);
            end else begin
                c_n = c_q + DIM_WIDTH'(1);
            end
        end else begin
            if (r_q == rows_q - DIM_WIDTH'(1)) begin
                r_n = '0;
                c_n = c_q + DIM_WIDTH'(1);
            end else begin
                r_n = r_q + DIM_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            rows_q      <= '0;
            cols_q      <= '0;
            tr_q        <= 1'b0;
            r_q         <= '0;
            c_q         <= '0;
            total_q     <= '0;
            issued_q    <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            addr_Mat_o  <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            infl_q      <= iss;
            infl_last_q <= iss && is_final;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (illegal) begin
                            err_o <= 1'b1;
                        end else begin
                            rows_q     <= rows_i;
                            cols_q     <= cols_i;
                            tr_q       <= transpose_i;
                            r_q        <= '0;
                            c_q        <= '0;
                            total_q    <= CNT_W'(rows_i) * CNT_W'(cols_i);
                            issued_q   <= '0;
                            addr_Mat_o <= '0;
                            busy_o     <= 1'b1;
                            state_q    <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (iss) begin
                        issued_q <= issued_q + CNT_W'(1);
                        r_q      <= r_n;
                        c_q      <= c_n;
                        if (is_final) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            addr_Mat_o <= ADDR_WIDTH'(compose_addr(r_n, c_n));
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && head[DATA_WIDTH]) begin
                        state_q <= ST_IDLE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    skid_fifo2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (infl_q),
        .data_i  ({infl_last_q, read_data_Mat_i}),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (fifo_count)
    );

    assign valid_o = (fifo_count != 2'd0);
    assign data_o  = head[DATA_WIDTH-1:0];
    assign last_o  = valid_o && head[DATA_WIDTH];

endmodule
